seq_math_unit: RTL and testbench
================================

// Module: seq_math_unit
// PURPOSE
//   Parametrised, clocked arithmetic unit. Supports add, subtract and sequential
//   (shift-add) multiply on WIDTH-bit unsigned operands, with a start/busy/done
//   handshake, registered result and status flags.
//   Sits between operand input registers (switches/FFs) and the display driver,
//   which samples result on done.
// PARAMETERS
//   WIDTH   4   operand width in bits (>=2); result is 2*WIDTH bits
// PORTS
//   clk      in   1          system clock, all logic on rising edge
//   rst      in   1          synchronous, active-high reset
//   start    in   1          request op; sampled only when unit is idle
//   op       in   2          00 add, 01 sub, 10 mul, 11 reserved
//   a        in   WIDTH      operand A (unsigned)
//   b        in   WIDTH      operand B (unsigned)
//   busy     out  1          high while a multiply is in progress
//   done     out  1          one-cycle pulse: result/flags updated this cycle
//   result   out  2*WIDTH    registered result
//   carry    out  1          add carry-out
//   borrow   out  1          sub borrow-out (a < b)
//   zero     out  1          result == 0 over all 2*WIDTH bits
//   err      out  1          last op was reserved (op=11)
// BEHAVIOUR
//   - Interface: one clock (clk); reset rst is synchronous, active-high.
//   - Reset: state IDLE; busy, done, result, carry, borrow, zero, err all 0.
//     Reset during MUL aborts it. No done is issued; result keeps reset value 0.
//   - FSM states:
//     - IDLE: start=1 latches a, b, op at that edge (edge N).
//       - add/sub/reserved: complete at edge N; done=1 for the following cycle;
//         stay IDLE.
//       - mul: go to MUL; busy=1 from edge N.
//     - MUL: acc, multiplicand and multiplier are held in internal registers.
//       Each cycle: if the multiplier LSB is 1, add the shifted multiplicand to
//       acc; then shift. The iteration counter runs 0..WIDTH-1. At edge N+WIDTH:
//       result<=acc, done=1 for one cycle, busy=0, return to IDLE.
//   - start while busy: ignored entirely. It is not queued. a, b and op changes
//     during MUL do not affect the operation.
//   - start in the cycle done is high: accepted normally (back-to-back allowed).
//   - Add: result[WIDTH-1:0]=(a+b) mod 2^WIDTH, upper bits 0, carry=bit WIDTH
//     of a+b, borrow=0.
//   - Sub: result[WIDTH-1:0]=(a-b) mod 2^WIDTH, upper bits 0, borrow=(a<b),
//     carry=0.
//   - Mul: result=a*b full 2*WIDTH bits, carry=0, borrow=0.
//   - Reserved (op=11): result=0, carry=borrow=0, err=1, done pulses.
//     err clears on the next completed legal op.
//   - zero, carry, borrow and err update only with result (on the done edge);
//     all outputs hold between ops.
//   - Latency: add/sub = 1 cycle (start edge to done cycle);
//     mul = WIDTH+1 cycles; busy high exactly WIDTH cycles.
// TESTING (WIDTH=4 unless noted)
//   1. add a=9 b=8 -> next cycle done=1, result=8'h01, carry=1, zero=0, busy
//      never high.
//   2. sub a=3 b=5 -> result=8'h0E, borrow=1. Then sub a=5 b=5 -> result=0,
//      zero=1, borrow=0.
//   3. mul a=15 b=15 -> busy high 4 cycles, done in 5th cycle, result=8'hE1.
//      Sweep all 256 a,b pairs against a model.
//   4. mul a=6 b=7, then pulse start with op=00 a=1 b=1 on cycle 2 of MUL ->
//      ignored, result=8'd42, single done.
//   5. mul started, rst asserted on cycle 2 -> next cycle all outputs 0, no
//      done. New add after reset works.
//   6. op=11 -> done pulse, err=1, result=0. Next add clears err.
//      Repeat tests 1-3 with WIDTH=8 (255*255=16'hFE01).

Source files
------------

// File: rtl/seq_math_unit.sv
// Clocked add/sub/shift-add multiply unit with start/busy/done handshake.
// Result and status flags are registered and only change on the done edge.
module seq_math_unit #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               carry,
  output logic               borrow,
  output logic               zero,
  output logic               err
);

  localparam int RW = 2 * WIDTH;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t         state_reg, state_next;
  logic [RW-1:0]  acc_reg, acc_next;
  logic [RW-1:0]  mcand_reg, mcand_next;
  logic [WIDTH-1:0] mplier_reg, mplier_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic [RW-1:0]  result_reg, result_next;
  logic           done_reg, done_next;
  logic           carry_reg, carry_next;
  logic           borrow_reg, borrow_next;
  logic           zero_reg, zero_next;
  logic           err_reg, err_next;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] diff;
  logic [RW-1:0]    partial;
  logic [RW-1:0]    acc_step;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = a - b;

  // Multiplicand gated by the current multiplier LSB.
  genvar gi;
  generate
    for (gi = 0; gi < RW; gi++) begin : g_partial
      assign partial[gi] = mcand_reg[gi] & mplier_reg[0];
    end
  endgenerate

  assign acc_step = acc_reg + partial;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      cnt_reg    <= '0;
      result_reg <= '0;
      done_reg   <= 1'b0;
      carry_reg  <= 1'b0;
      borrow_reg <= 1'b0;
      zero_reg   <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      acc_reg    <= acc_next;
      mcand_reg  <= mcand_next;
      mplier_reg <= mplier_next;
      cnt_reg    <= cnt_next;
      result_reg <= result_next;
      done_reg   <= done_next;
      carry_reg  <= carry_next;
      borrow_reg <= borrow_next;
      zero_reg   <= zero_next;
      err_reg    <= err_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    acc_next    = acc_reg;
    mcand_next  = mcand_reg;
    mplier_next = mplier_reg;
    cnt_next    = cnt_reg;
    result_next = result_reg;
    done_next   = 1'b0;
    carry_next  = carry_reg;
    borrow_next = borrow_reg;
    err_next    = err_reg;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          case (op)
            OP_ADD: begin
              result_next = {{WIDTH{1'b0}}, sum[WIDTH-1:0]};
              carry_next  = sum[WIDTH];
              borrow_next = 1'b0;
              err_next    = 1'b0;
              done_next   = 1'b1;
            end
            OP_SUB: begin
              result_next = {{WIDTH{1'b0}}, diff};
              carry_next  = 1'b0;
              borrow_next = (a < b);
              err_next    = 1'b0;
              done_next   = 1'b1;
            end
            OP_MUL: begin
              state_next  = S_MUL;
              acc_next    = '0;
              mcand_next  = {{WIDTH{1'b0}}, a};
              mplier_next = b;
              cnt_next    = '0;
            end
            default: begin
              result_next = '0;
              carry_next  = 1'b0;
              borrow_next = 1'b0;
              err_next    = 1'b1;
              done_next   = 1'b1;
            end
          endcase
        end
      end
      S_MUL: begin
        acc_next    = acc_step;
        mcand_next  = mcand_reg << 1;
        mplier_next = mplier_reg >> 1;
        cnt_next    = cnt_reg + 1'b1;
        // Last iteration writes the final accumulator straight to result.
        if (cnt_reg == LAST_ITER) begin
          state_next  = S_IDLE;
          result_next = acc_step;
          carry_next  = 1'b0;
          borrow_next = 1'b0;
          err_next    = 1'b0;
          done_next   = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase

    zero_next = done_next ? (result_next == '0) : zero_reg;
  end

  assign busy   = (state_reg == S_MUL);
  assign done   = done_reg;
  assign result = result_reg;
  assign carry  = carry_reg;
  assign borrow = borrow_reg;
  assign zero   = zero_reg;
  assign err    = err_reg;

endmodule

// File: tb/tb_seq_math_unit.sv
// Directed bench for seq_math_unit at WIDTH=4 and WIDTH=8 sharing clk/rst.
module tb_seq_math_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // WIDTH=4 instance
  logic       start4 = 1'b0;
  logic [1:0] op4 = 2'b00;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, carry4, borrow4, zero4, err4;
  logic [7:0] result4;

  // WIDTH=8 instance
  logic       start8 = 1'b0;
  logic [1:0] op8 = 2'b00;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, carry8, borrow8, zero8, err8;
  logic [15:0] result8;

  seq_math_unit #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .op(op4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .result(result4), .carry(carry4),
    .borrow(borrow4), .zero(zero4), .err(err4)
  );

  seq_math_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(result8), .carry(carry8),
    .borrow(borrow8), .zero(zero8), .err(err8)
  );

  int checks = 0;
  int errors = 0;
  int lat, bcyc, dcnt;
  logic [15:0] held;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle so outputs are sampled off the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op; return cycles from start edge to done and busy-cycle count.
  task automatic run4(input logic [1:0] o, input logic [3:0] x, input logic [3:0] y,
                      output int l, output int bc);
    start4 = 1'b1; op4 = o; a4 = x; b4 = y;
    step();
    start4 = 1'b0;
    l = 0; bc = 0;
    while (!done4 && l < 20) begin
      if (busy4) bc++;
      step();
      l++;
    end
    $display("w4 op=%0d a=%0d b=%0d -> result=%0h c=%0b bw=%0b z=%0b e=%0b lat=%0d busy=%0d",
             o, x, y, result4, carry4, borrow4, zero4, err4, l, bc);
  endtask

  task automatic run8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                      output int l, output int bc);
    start8 = 1'b1; op8 = o; a8 = x; b8 = y;
    step();
    start8 = 1'b0;
    l = 0; bc = 0;
    while (!done8 && l < 40) begin
      if (busy8) bc++;
      step();
      l++;
    end
    $display("w8 op=%0d a=%0d b=%0d -> result=%0h c=%0b bw=%0b z=%0b e=%0b lat=%0d busy=%0d",
             o, x, y, result8, carry8, borrow8, zero8, err8, l, bc);
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    chk("rst_busy",   32'(busy4),   32'd0);
    chk("rst_done",   32'(done4),   32'd0);
    chk("rst_result", 32'(result4), 32'd0);
    chk("rst_carry",  32'(carry4),  32'd0);
    chk("rst_borrow", 32'(borrow4), 32'd0);
    chk("rst_zero",   32'(zero4),   32'd0);
    chk("rst_err",    32'(err4),    32'd0);
    step();

    // 1. add 9+8 = 17 -> 0x01 with carry, single-cycle latency, no busy
    run4(2'b00, 4'd9, 4'd8, lat, bcyc);
    chk("add_done",   32'(done4),   32'd1);
    chk("add_result", 32'(result4), 32'h01);
    chk("add_carry",  32'(carry4),  32'd1);
    chk("add_zero",   32'(zero4),   32'd0);
    chk("add_lat",    32'(lat),     32'd0);
    chk("add_busy",   32'(bcyc),    32'd0);
    a4 = 4'd3; b4 = 4'd3;
    step();
    chk("add_done_pulse", 32'(done4),   32'd0);
    chk("add_hold",       32'(result4), 32'h01);
    chk("add_hold_carry", 32'(carry4),  32'd1);

    // 2. sub 3-5 wraps with borrow; 5-5 gives zero
    run4(2'b01, 4'd3, 4'd5, lat, bcyc);
    chk("sub_result", 32'(result4), 32'h0E);
    chk("sub_borrow", 32'(borrow4), 32'd1);
    chk("sub_carry",  32'(carry4),  32'd0);
    run4(2'b01, 4'd5, 4'd5, lat, bcyc);
    chk("sub0_result", 32'(result4), 32'h00);
    chk("sub0_zero",   32'(zero4),   32'd1);
    chk("sub0_borrow", 32'(borrow4), 32'd0);
    step();

    // 3. mul 15*15 = 225 after an add that left carry set
    run4(2'b00, 4'd9, 4'd8, lat, bcyc);
    run4(2'b10, 4'd15, 4'd15, lat, bcyc);
    chk("mul_done",   32'(done4),   32'd1);
    chk("mul_result", 32'(result4), 32'hE1);
    chk("mul_busy_n", 32'(bcyc),    32'd4);
    chk("mul_lat",    32'(lat),     32'd4);
    chk("mul_busy_at_done", 32'(busy4), 32'd0);
    chk("mul_carry",  32'(carry4),  32'd0);
    step();
    chk("mul_done_pulse", 32'(done4), 32'd0);

    // Full sweep, back-to-back starts in the done cycle
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        run4(2'b10, 4'(x), 4'(y), lat, bcyc);
        chk("sweep_result", 32'(result4), 32'(x * y));
        chk("sweep_zero",   32'(zero4),   32'((x * y) == 0));
        chk("sweep_lat",    32'(lat),     32'd4);
      end
    end
    step();

    // 4. start during MUL is ignored; exactly one done with 42
    start4 = 1'b1; op4 = 2'b10; a4 = 4'd6; b4 = 4'd7;
    step();
    start4 = 1'b0;
    step();
    start4 = 1'b1; op4 = 2'b00; a4 = 4'd1; b4 = 4'd1;
    step();
    start4 = 1'b0;
    dcnt = 0;
    held = '0;
    for (int i = 0; i < 10; i++) begin
      if (done4) begin
        dcnt++;
        held = 16'(result4);
      end
      step();
    end
    $display("w4 mul 6*7 with ignored start -> result=%0h dones=%0d", result4, dcnt);
    chk("ign_dones",  32'(dcnt),    32'd1);
    chk("ign_result", 32'(held),    32'd42);
    chk("ign_hold",   32'(result4), 32'd42);

    // 5. reset in cycle 2 of MUL aborts with no done
    start4 = 1'b1; op4 = 2'b10; a4 = 4'd5; b4 = 4'd3;
    step();
    start4 = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy",   32'(busy4),   32'd0);
    chk("abort_done",   32'(done4),   32'd0);
    chk("abort_result", 32'(result4), 32'd0);
    chk("abort_zero",   32'(zero4),   32'd0);
    dcnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (done4) dcnt++;
      step();
    end
    $display("w4 reset during mul -> result=%0h dones=%0d", result4, dcnt);
    chk("abort_no_done", 32'(dcnt), 32'd0);
    run4(2'b00, 4'd2, 4'd3, lat, bcyc);
    chk("post_rst_add", 32'(result4), 32'd5);

    // 6. reserved op flags err; next legal op clears it
    run4(2'b11, 4'd7, 4'd7, lat, bcyc);
    chk("rsv_done",   32'(done4),   32'd1);
    chk("rsv_err",    32'(err4),    32'd1);
    chk("rsv_result", 32'(result4), 32'd0);
    chk("rsv_zero",   32'(zero4),   32'd1);
    step();
    chk("rsv_err_hold", 32'(err4), 32'd1);
    run4(2'b00, 4'd1, 4'd1, lat, bcyc);
    chk("rsv_clear_err", 32'(err4),    32'd0);
    chk("rsv_clear_res", 32'(result4), 32'd2);
    step();

    // WIDTH=8 repeats
    run8(2'b00, 8'd200, 8'd100, lat, bcyc);
    chk("w8_add_result", 32'(result8), 32'h002C);
    chk("w8_add_carry",  32'(carry8),  32'd1);
    chk("w8_add_lat",    32'(lat),     32'd0);
    run8(2'b01, 8'd3, 8'd5, lat, bcyc);
    chk("w8_sub_result", 32'(result8), 32'h00FE);
    chk("w8_sub_borrow", 32'(borrow8), 32'd1);
    run8(2'b10, 8'd255, 8'd255, lat, bcyc);
    chk("w8_mul_result", 32'(result8), 32'hFE01);
    chk("w8_mul_busy_n", 32'(bcyc),    32'd8);
    chk("w8_mul_lat",    32'(lat),     32'd8);
    run8(2'b10, 8'd13, 8'd11, lat, bcyc);
    chk("w8_mul2_result", 32'(result8), 32'd143);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
